vxe_intu: RTL and testbench

VXE_INTU -- requirements
Module: vxe_intu

---
 rtl/vxe_intu.sv | 56 +++++
 tb/tb_vxe_intu.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/vxe_intu.sv
// Interrupt unit: latches per-source event pulses into raw/overrun status,
// applies the enable mask and drives a level interrupt to the host.
module vxe_intu #(
    parameter int NSRC = 4
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [NSRC-1:0] i_event,
    input  logic [NSRC-1:0] i_intu_msk,
    input  logic            i_intu_ack_vld,
    input  logic [NSRC-1:0] i_intu_ack,
    output logic [NSRC-1:0] o_intu_raw,
    output logic [NSRC-1:0] o_intu_act,
    output logic [NSRC-1:0] o_intu_ovf,
    output logic            o_intr
);

    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] raw_nxt;
    logic [NSRC-1:0] ovf_nxt;
    logic [NSRC-1:0] act_nxt;

    logic [NSRC-1:0] raw_p0;
    logic [NSRC-1:0] ovf_p0;
    logic [NSRC-1:0] act_p0;
    logic            intr_p0;

    // An event on the same edge as its ack wins, so a fresh event is never lost.
    always_comb begin
        clr     = i_intu_ack_vld ? i_intu_ack : '0;
        raw_nxt = (raw_p0 & ~clr) | i_event;
        ovf_nxt = (ovf_p0 & ~clr) | (i_event & raw_p0 & ~clr);
        act_nxt = raw_nxt & i_intu_msk;
    end

    // Stage p0: all outputs registered, no input-to-output combinational path
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            raw_p0  <= '0;
            ovf_p0  <= '0;
            act_p0  <= '0;
            intr_p0 <= 1'b0;
        end else begin
            raw_p0  <= raw_nxt;
            ovf_p0  <= ovf_nxt;
            act_p0  <= act_nxt;
            intr_p0 <= |act_nxt;
        end
    end

    assign o_intu_raw = raw_p0;
    assign o_intu_act = act_p0;
    assign o_intu_ovf = ovf_p0;
    assign o_intr     = intr_p0;

endmodule

// File: tb/tb_vxe_intu.sv
// Scoreboard bench for vxe_intu: directed scenarios followed by random traffic,
// checked against a per-bit behavioural model.
module tb_vxe_intu;

    logic       clk;
    logic       nrst;
    logic [3:0] i_event;
    logic [3:0] i_intu_msk;
    logic       i_intu_ack_vld;
    logic [3:0] i_intu_ack;
    logic [3:0] o_intu_raw;
    logic [3:0] o_intu_act;
    logic [3:0] o_intu_ovf;
    logic       o_intr;

    vxe_intu #(.NSRC(4)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .i_event        (i_event),
        .i_intu_msk     (i_intu_msk),
        .i_intu_ack_vld (i_intu_ack_vld),
        .i_intu_ack     (i_intu_ack),
        .o_intu_raw     (o_intu_raw),
        .o_intu_act     (o_intu_act),
        .o_intu_ovf     (o_intu_ovf),
        .o_intr         (o_intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] raw;
        logic [3:0] act;
        logic [3:0] ovf;
        logic       intr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [3:0] m_raw = '0;
    logic [3:0] m_ovf = '0;

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: one expectation per clock edge that followed a stimulus step
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("raw",  o_intu_raw, e.raw);
            chk("act",  o_intu_act, e.act);
            chk("ovf",  o_intu_ovf, e.ovf);
            chk("intr", {3'b000, o_intr}, {3'b000, e.intr});
        end
    end

    // Reference: each source behaves as a sticky flag with an overrun flag
    task automatic drive(input logic [3:0] ev, input logic [3:0] msk,
                         input logic av, input logic [3:0] ack);
        exp_t e;
        @(negedge clk);
        i_event        = ev;
        i_intu_msk     = msk;
        i_intu_ack_vld = av;
        i_intu_ack     = ack;
        for (int i = 0; i < 4; i++) begin
            bit acked;
            acked = av && ack[i];
            if (ev[i]) begin
                if (acked)          m_ovf[i] = 1'b0;
                else if (m_raw[i])  m_ovf[i] = 1'b1;
                m_raw[i] = 1'b1;
            end else if (acked) begin
                m_raw[i] = 1'b0;
                m_ovf[i] = 1'b0;
            end
        end
        e.raw  = m_raw;
        e.ovf  = m_ovf;
        e.act  = m_raw & msk;
        e.intr = (e.act != 4'h0);
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d want=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_raw"},  o_intu_raw, 4'h0);
        chk({tag, "_act"},  o_intu_act, 4'h0);
        chk({tag, "_ovf"},  o_intu_ovf, 4'h0);
        chk({tag, "_intr"}, {3'b000, o_intr}, 4'h0);
    endtask

    initial begin
        nrst           = 1'b0;
        i_event        = '0;
        i_intu_msk     = '0;
        i_intu_ack_vld = 1'b0;
        i_intu_ack     = '0;
        #3;
        reset_check("por");
        #4;
        nrst = 1'b1;

        // Single event, then ack three edges later
        drive(4'h1, 4'h1, 1'b0, 4'h0);
        drive(4'h0, 4'h1, 1'b0, 4'h0);
        drive(4'h0, 4'h1, 1'b0, 4'h0);
        drive(4'h0, 4'h1, 1'b1, 4'h1);

        // Masked events, mask opened later
        drive(4'h6, 4'h0, 1'b0, 4'h0);
        drive(4'h0, 4'h4, 1'b0, 4'h0);
        drive(4'h0, 4'h4, 1'b1, 4'hf);

        // Overrun then clear
        drive(4'h2, 4'h0, 1'b0, 4'h0);
        drive(4'h2, 4'h0, 1'b0, 4'h0);
        drive(4'h0, 4'h2, 1'b1, 4'h2);

        // Event and ack together on a clear bit
        drive(4'h8, 4'h8, 1'b1, 4'h8);
        drive(4'h0, 4'h8, 1'b1, 4'h8);

        // Ack ignored without valid, then honoured
        drive(4'hf, 4'hf, 1'b0, 4'h0);
        drive(4'h0, 4'hf, 1'b0, 4'hf);
        drive(4'h0, 4'hf, 1'b1, 4'hf);
        drive(4'h0, 4'hf, 1'b1, 4'hf);

        // Reset between edges with everything set
        drive(4'hf, 4'hf, 1'b0, 4'h0);
        drive(4'h0, 4'hf, 1'b0, 4'h0);
        wait_drain();
        @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        reset_check("mid");
        m_raw = '0;
        m_ovf = '0;
        #1;
        nrst = 1'b1;
        drive(4'h1, 4'hf, 1'b0, 4'h0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            logic [3:0] ev, msk, ack;
            logic av;
            ev  = 4'($urandom & $urandom);
            msk = 4'($urandom);
            ack = 4'($urandom);
            av  = 1'($urandom_range(0, 1));
            drive(ev, msk, av, ack);
        end
        drive(4'h0, 4'h0, 1'b0, 4'h0);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
